// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: 2-flop synchroniser, per-channel debounce,
// registered edge pulses, toggle state and a shared rise-event counter.
module input_conditioner #(
  parameter int NCH       = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  raw_in,
  input  logic [NCH-1:0]  tog_clr,
  input  logic            evt_clr,
  output logic [NCH-1:0]  stable,
  output logic [NCH-1:0]  rise,
  output logic [NCH-1:0]  fall,
  output logic [NCH-1:0]  toggle,
  output logic            any_evt,
  output logic [CNTW-1:0] evt_cnt
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [NCH-1:0]  s1_q, s2_q;
  logic [NCH-1:0]  stable_q, stable_d;
  logic [NCH-1:0]  rise_q, rise_d;
  logic [NCH-1:0]  fall_q, fall_d;
  logic [NCH-1:0]  toggle_q, toggle_d;
  logic            any_evt_q, any_evt_d;
  logic [CNTW-1:0] evt_cnt_q, evt_cnt_d;
  logic [CNTW-1:0] pop;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];

  // Pulses, toggle and counter all derive from the next stable value so they
  // become visible on the same edge as the new stable level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == LAST) stable_d[i] = s2_q[i];
        else                  cnt_d[i]    = cnt_q[i] + ONE;
      end
    end
    rise_d    = stable_d & ~stable_q;
    fall_d    = ~stable_d & stable_q;
    toggle_d  = (toggle_q ^ rise_d) & ~tog_clr;
    any_evt_d = |(rise_d | fall_d);
    pop = '0;
    for (int i = 0; i < NCH; i++) pop = pop + CNTW'(rise_d[i]);
    evt_cnt_d = evt_clr ? '0 : evt_cnt_q + pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      toggle_q  <= '0;
      any_evt_q <= 1'b0;
      evt_cnt_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= raw_in;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      toggle_q  <= toggle_d;
      any_evt_q <= any_evt_d;
      evt_cnt_q <= evt_cnt_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable  = stable_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign toggle  = toggle_q;
  assign any_evt = any_evt_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (NCH=5, DB_CYCLES=4); a second 4-bit-counter
// instance shares the stimulus so counter wrap is reachable in few presses.
module tb_input_conditioner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  raw_in = '0;
  logic [4:0]  tog_clr = '0;
  logic        evt_clr = 1'b0;
  logic [4:0]  stable, rise, fall, toggle;
  logic        any_evt;
  logic [15:0] evt_cnt;
  logic [4:0]  w_stable, w_rise, w_fall, w_toggle;
  logic        w_any_evt;
  logic [3:0]  w_evt_cnt;

  int nchecks = 0;
  int nerrors = 0;
  logic [4:0] exp_tog = '0;

  input_conditioner #(.NCH(5), .DB_CYCLES(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .tog_clr(tog_clr), .evt_clr(evt_clr),
    .stable(stable), .rise(rise), .fall(fall), .toggle(toggle),
    .any_evt(any_evt), .evt_cnt(evt_cnt));

  input_conditioner #(.NCH(5), .DB_CYCLES(4), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .raw_in(raw_in), .tog_clr(tog_clr), .evt_clr(evt_clr),
    .stable(w_stable), .rise(w_rise), .fall(w_fall), .toggle(w_toggle),
    .any_evt(w_any_evt), .evt_cnt(w_evt_cnt));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cnt();
    evt_clr = 1'b1;
    step(1);
    evt_clr = 1'b0;
  endtask

  // Press and fully release a channel mask; rise lands 6 steps after the drive.
  task automatic press(input logic [4:0] m);
    raw_in = m;
    step(6);
    exp_tog = exp_tog ^ m;
    raw_in = '0;
    step(7);
  endtask

  task automatic test_reset();
    raw_in = 5'b11111;
    step(3);
    nchecks++;
    if ({stable, rise, fall, toggle, any_evt, evt_cnt} !== '0) begin
      nerrors++;
      $display("FAIL reset_outputs: got stable=%b rise=%b fall=%b toggle=%b any=%b cnt=%h, want all 0",
               stable, rise, fall, toggle, any_evt, evt_cnt);
    end
    raw_in = '0;
    step(1);
    rst = 1'b0;
    step(8);
    nchecks++;
    if ({stable, rise, fall, toggle, evt_cnt} !== '0) begin
      nerrors++;
      $display("FAIL post_reset_idle: got stable=%b toggle=%b cnt=%h, want 0", stable, toggle, evt_cnt);
    end
  endtask

  task automatic test_clean_press();
    raw_in = 5'b00001;
    step(5);
    nchecks++;
    if (stable !== 5'b0 || rise !== 5'b0) begin
      nerrors++;
      $display("FAIL press_early: got stable=%b rise=%b, want 00000 00000", stable, rise);
    end
    step(1);
    exp_tog[0] = ~exp_tog[0];
    nchecks++;
    if (stable !== 5'b00001 || rise !== 5'b00001 || fall !== 5'b0 || any_evt !== 1'b1) begin
      nerrors++;
      $display("FAIL press_edge: got stable=%b rise=%b fall=%b any=%b, want 00001 00001 00000 1",
               stable, rise, fall, any_evt);
    end
    nchecks++;
    if (toggle !== exp_tog || evt_cnt !== 16'd1) begin
      nerrors++;
      $display("FAIL press_tog_cnt: got toggle=%b cnt=%0d, want %b 1", toggle, evt_cnt, exp_tog);
    end
    step(1);
    nchecks++;
    if (rise !== 5'b0 || any_evt !== 1'b0 || stable !== 5'b00001 || evt_cnt !== 16'd1) begin
      nerrors++;
      $display("FAIL press_pulse_len: got rise=%b any=%b stable=%b cnt=%0d, want 00000 0 00001 1",
               rise, any_evt, stable, evt_cnt);
    end
    step(12);
    raw_in = '0;
    step(6);
    nchecks++;
    if (fall !== 5'b00001 || rise !== 5'b0 || stable !== 5'b0 || any_evt !== 1'b1 || evt_cnt !== 16'd1) begin
      nerrors++;
      $display("FAIL release_edge: got fall=%b rise=%b stable=%b any=%b cnt=%0d, want 00001 00000 00000 1 1",
               fall, rise, stable, any_evt, evt_cnt);
    end
    step(1);
  endtask

  task automatic test_bounce();
    int bad;
    clear_cnt();
    bad = 0;
    raw_in = 5'b00100;
    for (int i = 0; i < 3; i++) begin step(1); if (rise !== 0 || fall !== 0 || stable !== 0) bad++; end
    raw_in = 5'b00000;
    for (int i = 0; i < 2; i++) begin step(1); if (rise !== 0 || fall !== 0 || stable !== 0) bad++; end
    raw_in = 5'b00100;
    for (int i = 0; i < 5; i++) begin step(1); if (rise !== 0 || fall !== 0 || stable !== 0) bad++; end
    nchecks++;
    if (bad != 0) begin
      nerrors++;
      $display("FAIL bounce_quiet: got %0d cycles with activity, want 0", bad);
    end
    step(1);
    exp_tog[2] = ~exp_tog[2];
    nchecks++;
    if (rise !== 5'b00100 || stable !== 5'b00100 || evt_cnt !== 16'd1 || toggle !== exp_tog) begin
      nerrors++;
      $display("FAIL bounce_rise: got rise=%b stable=%b cnt=%0d toggle=%b, want 00100 00100 1 %b",
               rise, stable, evt_cnt, toggle, exp_tog);
    end
    raw_in = '0;
    step(7);
  endtask

  task automatic test_multi_channel();
    clear_cnt();
    raw_in = 5'b11111;
    step(5);
    nchecks++;
    if (rise !== 5'b0) begin
      nerrors++;
      $display("FAIL multi_early: got rise=%b, want 00000", rise);
    end
    step(1);
    exp_tog = exp_tog ^ 5'b11111;
    nchecks++;
    if (rise !== 5'b11111 || fall !== 5'b0 || evt_cnt !== 16'd5 || any_evt !== 1'b1 || toggle !== exp_tog) begin
      nerrors++;
      $display("FAIL multi_rise: got rise=%b fall=%b cnt=%0d any=%b toggle=%b, want 11111 00000 5 1 %b",
               rise, fall, evt_cnt, any_evt, toggle, exp_tog);
    end
    step(1);
    raw_in = '0;
    step(6);
    nchecks++;
    if (fall !== 5'b11111 || rise !== 5'b0 || evt_cnt !== 16'd5 || stable !== 5'b0) begin
      nerrors++;
      $display("FAIL multi_fall: got fall=%b rise=%b cnt=%0d stable=%b, want 11111 00000 5 00000",
               fall, rise, evt_cnt, stable);
    end
    step(1);
  endtask

  task automatic test_wrap_and_clear();
    clear_cnt();
    press(5'b11111);
    press(5'b11111);
    press(5'b01111);
    nchecks++;
    if (w_evt_cnt !== 4'hE || evt_cnt !== 16'd14) begin
      nerrors++;
      $display("FAIL wrap_preload: got narrow=%h wide=%0d, want e 14", w_evt_cnt, evt_cnt);
    end
    raw_in = 5'b00111;
    step(6);
    exp_tog = exp_tog ^ 5'b00111;
    nchecks++;
    if (w_evt_cnt !== 4'h1 || evt_cnt !== 16'd17 || w_rise !== 5'b00111) begin
      nerrors++;
      $display("FAIL wrap_count: got narrow=%h wide=%0d rise=%b, want 1 17 00111", w_evt_cnt, evt_cnt, w_rise);
    end
    raw_in = '0;
    step(7);
    raw_in = 5'b00001;
    step(5);
    evt_clr = 1'b1;
    step(1);
    evt_clr = 1'b0;
    exp_tog[0] = ~exp_tog[0];
    nchecks++;
    if (rise !== 5'b00001 || evt_cnt !== 16'd0 || w_evt_cnt !== 4'd0 || toggle !== exp_tog) begin
      nerrors++;
      $display("FAIL evt_clr_collide: got rise=%b cnt=%0d narrow=%0d toggle=%b, want 00001 0 0 %b",
               rise, evt_cnt, w_evt_cnt, toggle, exp_tog);
    end
    step(1);
    nchecks++;
    if (evt_cnt !== 16'd0) begin
      nerrors++;
      $display("FAIL evt_clr_after: got cnt=%0d, want 0", evt_cnt);
    end
    raw_in = '0;
    step(7);
  endtask

  task automatic test_tog_clr_collision();
    raw_in = 5'b00010;
    step(5);
    tog_clr = 5'b00010;
    step(1);
    tog_clr = '0;
    exp_tog[1] = 1'b0;
    nchecks++;
    if (rise !== 5'b00010 || toggle !== exp_tog) begin
      nerrors++;
      $display("FAIL tog_clr_collide: got rise=%b toggle=%b, want 00010 %b", rise, toggle, exp_tog);
    end
    raw_in = '0;
    step(7);
    raw_in = 5'b00010;
    step(6);
    exp_tog[1] = 1'b1;
    nchecks++;
    if (toggle !== exp_tog || rise !== 5'b00010) begin
      nerrors++;
      $display("FAIL tog_next_press: got toggle=%b rise=%b, want %b 00010", toggle, rise, exp_tog);
    end
    raw_in = '0;
    step(7);
  endtask

  task automatic test_reset_mid_debounce();
    int nrise;
    raw_in = 5'b01000;
    step(2);
    rst = 1'b1;
    #1;
    nchecks++;
    if ({stable, rise, fall, toggle, any_evt, evt_cnt} !== '0) begin
      nerrors++;
      $display("FAIL mid_reset_outputs: got stable=%b rise=%b toggle=%b any=%b cnt=%0d, want all 0",
               stable, rise, toggle, any_evt, evt_cnt);
    end
    step(3);
    nchecks++;
    if ({stable, rise, fall, toggle, any_evt, evt_cnt} !== '0) begin
      nerrors++;
      $display("FAIL mid_reset_hold: got stable=%b rise=%b toggle=%b cnt=%0d, want all 0",
               stable, rise, toggle, evt_cnt);
    end
    rst = 1'b0;
    exp_tog = '0;
    nrise = 0;
    for (int i = 0; i < 5; i++) begin step(1); if (rise !== 0 || stable !== 0) nrise++; end
    nchecks++;
    if (nrise != 0) begin
      nerrors++;
      $display("FAIL post_release_early: got %0d early events, want 0", nrise);
    end
    step(1);
    nchecks++;
    if (stable !== 5'b01000 || rise !== 5'b01000 || evt_cnt !== 16'd1 || toggle !== 5'b01000) begin
      nerrors++;
      $display("FAIL post_release_rise: got stable=%b rise=%b cnt=%0d toggle=%b, want 01000 01000 1 01000",
               stable, rise, evt_cnt, toggle);
    end
    nrise = 0;
    for (int i = 0; i < 8; i++) begin step(1); if (rise !== 0) nrise++; end
    nchecks++;
    if (nrise != 0 || stable !== 5'b01000) begin
      nerrors++;
      $display("FAIL post_release_single: got %0d extra rises stable=%b, want 0 01000", nrise, stable);
    end
    raw_in = '0;
    step(7);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_channel();
    test_wrap_and_clear();
    test_tog_clr_collision();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NCH, default 5: number of independent input channels, range 1..32.
REQ-002 Parameter DB_CYCLES, default 1000000: debounce qualification length in clk cycles, minimum 1.
REQ-003 Parameter CNTW, default 16: width of the event counter.
REQ-004 clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 raw_in  input  NCH  asynchronous raw button/switch levels, one bit per channel.
REQ-007 tog_clr  input  NCH  per-channel synchronous clear of toggle state.
REQ-008 evt_clr  input  1  synchronous clear of evt_cnt.
REQ-009 stable  output  NCH  debounced level per channel.
REQ-010 rise  output  NCH  one-cycle pulse on each debounced 0->1 transition.
REQ-011 fall  output  NCH  one-cycle pulse on each debounced 1->0 transition.
REQ-012 toggle  output  NCH  per-channel toggle state that flips on each rise.
REQ-013 any_evt  output  1  OR-reduction of rise and fall.
REQ-014 evt_cnt  output  CNTW  running count of rise events over all channels.

Function
REQ-015 Each raw_in bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use.
REQ-016 Each channel SHALL own a debounce counter of width clog2(DB_CYCLES+1).
REQ-017 Debounce counter, s2 == stable: counter <= 0.
REQ-018 Debounce counter, s2 != stable and counter < DB_CYCLES-1: counter increments.
REQ-019 Debounce counter, s2 != stable and counter == DB_CYCLES-1: stable <= s2 and counter <= 0.
REQ-020 Latency: a raw_in change captured into s1 at edge k, then held, SHALL update stable at edge k+1+DB_CYCLES (DB_CYCLES=1 gives k+2).
REQ-021 Glitch rejection: any s2 excursion shorter than DB_CYCLES cycles SHALL leave stable unchanged.
REQ-022 A glitch SHALL return that channel's counter to 0.
REQ-023 rise[i] and fall[i] SHALL be registered outputs, high for exactly the first cycle in which the new stable[i] value is visible.
REQ-024 rise[i] and fall[i] SHALL never be high together.
REQ-025 toggle[i] SHALL invert on the edge that raises rise[i].
REQ-026 tog_clr[i] SHALL force toggle[i] to 0 on the next edge.
REQ-027 Simultaneous tog_clr[i] and rise[i] event: clear wins, toggle[i]=0.
REQ-028 any_evt SHALL be registered and asserted in the same cycle as any rise or fall bit.
REQ-029 evt_cnt SHALL add popcount(rise) each cycle; popcount spans 0..NCH, zero-extended to CNTW bits.
REQ-030 evt_cnt SHALL wrap modulo 2^CNTW, with no saturation and no overflow flag.
REQ-031 evt_clr SHALL set evt_cnt to 0 on the next edge.
REQ-032 Simultaneous evt_clr and rise events: clear wins, evt_cnt=0, and those events are not counted.
REQ-033 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be qualified and reported in the same cycle.

Reset
REQ-034 While rst=1, the following SHALL all be 0: s1, s2, every debounce counter, stable, rise, fall, toggle, any_evt and evt_cnt.
REQ-035 Assertion of rst mid-qualification SHALL discard the partial count with no pulse emitted.
REQ-036 A raw_in held high through reset release SHALL produce stable=1 and one rise pulse DB_CYCLES+1 edges after the first post-release capture.

Verification (NCH=5, DB_CYCLES=4, CNTW=16)
REQ-037 Clean press: raw_in[0] 0->1 held 20 cycles -> stable[0]=1 at edge k+5, rise[0] high exactly 1 cycle, toggle[0]=1, evt_cnt=1, any_evt 1 cycle.
REQ-038 Bounce: raw_in[2] high for 3 cycles, low for 2 cycles, then high held -> no event during bounce; a single rise[2] occurs 5 edges after the final high capture; evt_cnt=1.
REQ-039 Multi-channel: raw_in 00000->11111 in one cycle -> rise=11111 in one cycle and evt_cnt increments by 5; release -> fall=11111 in one cycle and evt_cnt unchanged.
REQ-040 Wrap and clear: preload evt_cnt to 0xFFFE by repeated presses, then press 3 channels together -> evt_cnt=0x0001; evt_clr coincident with a rise -> evt_cnt=0 and toggle still flips.
REQ-041 Toggle clear collision: tog_clr[1]=1 in the same cycle as rise[1] -> toggle[1]=0; the next press -> toggle[1]=1.
REQ-042 Reset mid-debounce: raw_in[3] high, rst asserted after 2 cycles, then released with raw_in[3] still high -> all outputs 0 during reset; stable[3]=1 with one rise[3] at the post-release latency of REQ-036.
